// File: rtl/sort_arbiter.sv
// sort_arbiter: two-requester round-robin front end for a shared merge sorter; optional WAIT abort under SORT_ARB_TIMEOUT_EN.
module sort_arbiter #(
  parameter int STRING_LEN = 8,
  parameter int REC_W = 3,
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic req0,
  input  logic req1,
  input  logic [STRING_LEN-1:0][REC_W-1:0][7:0] data_in0,
  input  logic [STRING_LEN-1:0][REC_W-1:0][7:0] data_in1,
  output logic done0,
  output logic done1,
  output logic [STRING_LEN-1:0][REC_W-1:0][7:0] data_out,
  output logic err,
  output logic eng_start,
  output logic [STRING_LEN-1:0][REC_W-1:0][7:0] eng_data_in,
  output logic [1:0] eng_sort_num,
  input  logic [STRING_LEN-1:0][REC_W-1:0][7:0] eng_data_out,
  input  logic eng_sorted
);
  typedef enum logic [1:0] {IDLE, START, WAIT, DELIVER} state_t;
  state_t state, state_n;
  logic gnt, gnt_n, ptr, abort, fail;
`ifdef SORT_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;
  assign abort = !eng_sorted && cnt == CW'(TIMEOUT - 1);
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else cnt <= state == WAIT ? cnt + 1'b1 : '0;
`else
  // With the watchdog compiled out a job can never abort.
  assign abort = TIMEOUT < 0;
`endif
  always_comb begin
    gnt_n = (req0 && req1) ? ptr : req1;
    state_n = state == IDLE  ? ((req0 || req1) ? START : IDLE)
            : state == START ? WAIT
            : state == WAIT  ? ((eng_sorted || abort) ? DELIVER : WAIT)
            : IDLE;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      gnt <= 1'b0;
      ptr <= 1'b0;
      fail <= 1'b0;
      eng_data_in <= '0;
      eng_sort_num <= '0;
      data_out <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && (req0 || req1)) begin
        gnt <= gnt_n;
        eng_data_in <= gnt_n ? data_in1 : data_in0;
        eng_sort_num <= {1'b0, gnt_n};
      end
      if (state == WAIT) fail <= abort;
      if (state == WAIT && eng_sorted) data_out <= eng_data_out;
      if (state == DELIVER) ptr <= ~gnt;
    end
  assign eng_start = state == START;
  assign done0 = state == DELIVER && !gnt;
  assign done1 = state == DELIVER && gnt;
  assign err = state == DELIVER && fail;
endmodule

// File: doc/sort_arbiter.md
SORT_ARBITER -- requirements
Module: sort_arbiter

Interface
REQ-001 Parameter STRING_LEN, default 8: records per sort job.
REQ-002 Parameter REC_W, default 3: bytes per record; byte [REC_W-1] is the suffix index.
REQ-003 Parameter TIMEOUT, default 255: maximum WAIT cycles before abort; used only with SORT_ARB_TIMEOUT_EN.
REQ-004 clk  in  1  sole clock; all logic on rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 req0, req1  in  1 each  job request; level, held until matching done.
REQ-007 data_in0, data_in1  in  8 x [STRING_LEN][REC_W]  job records per requester.
REQ-008 done0, done1  out  1 each  one-cycle completion pulse per requester.
REQ-009 data_out  out  8 x [STRING_LEN][REC_W]  registered sorted result of last job.
REQ-010 err  out  1  qualifies done pulse: job aborted.
REQ-011 eng_start  out  1  one-cycle start pulse to the shared merge sorter.
REQ-012 eng_data_in  out  8 x [STRING_LEN][REC_W]  registered job data to sorter.
REQ-013 eng_sort_num  out  2  sorter job tag: 2'h0 for requester 0, 2'h1 for requester 1.
REQ-014 eng_data_out  in  8 x [STRING_LEN][REC_W]  sorter result.
REQ-015 eng_sorted  in  1  sorter completion, sampled only in WAIT.

Function
REQ-016 States: IDLE, START, WAIT, DELIVER; one job in flight at any time.
REQ-017 IDLE: no requests -> stay; else grant one requester, latch its data_in into eng_data_in, set eng_sort_num, -> START.
REQ-018 Arbitration: single request wins; both requesting -> requester not served last wins; priority pointer updates only on DELIVER.
REQ-019 START: eng_start=1 for exactly this cycle -> WAIT.
REQ-020 WAIT: eng_sorted=1 -> latch eng_data_out into data_out, -> DELIVER; else stay.
REQ-021 DELIVER: doneN=1 for granted requester only, err=0, -> IDLE.
REQ-022 Latency: req sampled in IDLE at cycle 0 -> eng_start at cycle 1 -> doneN one cycle after the cycle eng_sorted is seen in WAIT.
REQ-023 FSM always spends at least one cycle in IDLE between jobs; a req still high there starts a new job.
REQ-024 Deassertion of the granted req after START is ignored; job completes and done is still pulsed.
REQ-025 Requests arriving during START/WAIT/DELIVER wait; no preemption.
REQ-026 eng_data_in and eng_sort_num hold stable from IDLE grant until next grant.
REQ-027 done0 and done1 are never high together; eng_start never pulses outside START.

Reset
REQ-028 rst low: state=IDLE, done0=done1=0, err=0, eng_start=0, eng_sort_num=0, data_out and eng_data_in all 8'h0, pointer favors requester 0, timeout counter 0.
REQ-029 Reset mid-job abandons the job with no done pulse; eng_sorted after reset release is ignored outside WAIT.

Configuration
REQ-030 Macro SORT_ARB_TIMEOUT_EN defined: counter clears on entering WAIT, increments each WAIT cycle; reaching TIMEOUT without eng_sorted -> DELIVER with err=1, data_out unchanged.
REQ-031 eng_sorted in the same cycle the counter reaches TIMEOUT takes precedence: normal completion, err=0.
REQ-032 Macro undefined: no counter, WAIT indefinite, err tied 0.

Verification
REQ-033 Only req0, records suffix 0..7 reversed, sorter done 10 cycles after start -> eng_start at cycle 1, eng_sort_num=0, done0 pulse one cycle after eng_sorted, data_out=sorter result.
REQ-034 req0 and req1 high together from reset -> req0 served first, then req1, then req0 again; done0/done1 alternate.
REQ-035 req1 asserted during req0 WAIT -> no second eng_start until done0 pulse plus one IDLE cycle.
REQ-036 Granted req drops in WAIT -> done still pulsed, no re-grant afterward.
REQ-037 rst low in WAIT, then eng_sorted=1 -> no done, outputs at reset values, state IDLE.
REQ-038 SORT_ARB_TIMEOUT_EN, TIMEOUT=16, eng_sorted never -> done0 with err=1 after 16 WAIT cycles, data_out unchanged; eng_sorted at cycle 16 -> err=0.
